dmem_mmio: RTL

Data-side memory for the single-cycle MIPS core. Consumes the core's `memwrite`, `aluout` (address) and `writedata`, and returns `readdata` in the same cycle. Decodes each access to either a word-addressed RAM or a small MMIO page: GPIO registers, a free-running cycle counter, and a compare-match timer with interrupt flag.

---
 rtl/dmem_mmio.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// Data memory plus MMIO page (GPIO, cycle counter, compare-match timer) for the single-cycle MIPS core.
// Define DMEM_MMIO_TIMER_EN to build the timer registers (0x0C-0x14) and irq; otherwise they read 0 and irq is 0.
module dmem_mmio #(
  parameter int RAM_AW = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        irq
);

  localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN  = 6'h01;
  localparam logic [5:0] OFF_CYCLE    = 6'h02;
`ifdef DMEM_MMIO_TIMER_EN
  localparam logic [5:0] OFF_TCMP     = 6'h03;
  localparam logic [5:0] OFF_TCTRL    = 6'h04;
  localparam logic [5:0] OFF_TCNT     = 6'h05;
`endif

  logic              is_ram;
  logic              is_mmio;
  logic [5:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              mmio_we;
  logic              wr_gpio;
  logic              unused_addr_lsbs;

  assign is_ram           = ~a[31];
  assign is_mmio          = (a[31:8] == 24'hFFFFFF);
  assign reg_sel          = a[7:2];
  assign ram_idx          = a[RAM_AW+1:2];
  assign ram_we           = we & is_ram;
  assign mmio_we          = we & is_mmio;
  assign wr_gpio          = mmio_we && (reg_sel == OFF_GPIO_OUT);
  assign unused_addr_lsbs = ^a[1:0];

  // RAM: not reset; combinational read returns the pre-write word during a write cycle
  logic [31:0] ram_q [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wd;
    end
  end

  logic [7:0]  gpio_out_q, gpio_out_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wr_gpio) begin
      gpio_out_d = wd[7:0];
    end
    cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cycle_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      cycle_q    <= cycle_d;
    end
  end

  assign gpio_out = gpio_out_q;

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] tcmp_q, tcmp_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic        match;
  logic        wr_tcmp, wr_tctrl, wr_tcnt;
  logic [31:0] tctrl_rd;

  assign wr_tcmp  = mmio_we && (reg_sel == OFF_TCMP);
  assign wr_tctrl = mmio_we && (reg_sel == OFF_TCTRL);
  assign wr_tcnt  = mmio_we && (reg_sel == OFF_TCNT);
  assign tctrl_rd = {28'd0, pend_q, ie_q, auto_q, en_q};

  // Hardware update first, then CPU writes override their fields; a match still wins over W1C of PEND
  always_comb begin
    tcmp_d = tcmp_q;
    tcnt_d = tcnt_q;
    en_d   = en_q;
    auto_d = auto_q;
    ie_d   = ie_q;
    pend_d = pend_q;
    match  = en_q && (tcnt_q == tcmp_q);

    if (en_q) begin
      if (match) begin
        if (auto_q) begin
          tcnt_d = '0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end

    if (wr_tcmp) begin
      tcmp_d = wd;
    end
    if (wr_tcnt) begin
      tcnt_d = wd;
    end
    if (wr_tctrl) begin
      en_d   = wd[0];
      auto_d = wd[1];
      ie_d   = wd[2];
      if (wd[3]) begin
        pend_d = 1'b0;
      end
    end
    if (match) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcmp_q <= '0;
      tcnt_q <= '0;
      en_q   <= 1'b0;
      auto_q <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      tcmp_q <= tcmp_d;
      tcnt_q <= tcnt_d;
      en_q   <= en_d;
      auto_q <= auto_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
    end
  end

  assign irq = pend_q & ie_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd = '0;
    if (is_ram) begin
      rd = ram_q[ram_idx];
    end else if (is_mmio) begin
      case (reg_sel)
        OFF_GPIO_OUT: rd = {24'd0, gpio_out_q};
        OFF_GPIO_IN:  rd = {24'd0, sync2_q};
        OFF_CYCLE:    rd = cycle_q;
`ifdef DMEM_MMIO_TIMER_EN
        OFF_TCMP:     rd = tcmp_q;
        OFF_TCTRL:    rd = tctrl_rd;
        OFF_TCNT:     rd = tcnt_q;
`endif
        default:      rd = '0;
      endcase
    end
  end

endmodule
